// File: rtl/ifmap_framer_pkg.sv
// Shared FSM state type and tagged-word bit positions for the IFMap row framer.
package ifmap_framer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  function automatic int START_BIT(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int END_BIT(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/sync_fifo_showahead.sv
// Show-ahead synchronous FIFO, any DEPTH >= 2; data visible one cycle after push.
// Push is dropped when full and pop when empty; rdata reads 0 while empty.
module sync_fifo_showahead #(
  parameter int WIDTH      = 10,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  push_en;
  logic                  pop_en;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wptr] <= wdata;
  end

  // Explicit wrap so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
      if (pop_en)  rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifmap_row_framer.sv
// Tags activation words with start/end-of-row flags and buffers them for the PE.
// Optional pop counter output words_sent is enabled by IFMAP_FRAMER_CNT_EN.
module ifmap_row_framer
  import ifmap_framer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int ROW_LEN_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW_LEN_WIDTH-1:0] row_len_in,
  input  logic [ROW_LEN_WIDTH-1:0] num_rows_in,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [DATA_WIDTH+1:0]    dout,
  output logic                     valid,
  input  logic                     ren,
  output logic                     busy,
  output logic                     done
`ifdef IFMAP_FRAMER_CNT_EN
  ,
  output logic [15:0]              words_sent
`endif
);

  localparam int SB = START_BIT(DATA_WIDTH);
  localparam int EB = END_BIT(DATA_WIDTH);
  localparam logic [ROW_LEN_WIDTH-1:0] RL_ONE = ROW_LEN_WIDTH'(1);

  state_t                   state, state_nxt;
  logic [ROW_LEN_WIDTH-1:0] row_len, num_rows, col, row;
  logic                     cfg_load, push, full, empty;
  logic                     start_flag, end_flag, last_row;
  logic [DATA_WIDTH+1:0]    wdata;
  logic [ADDR_WIDTH:0]      count;

  assign start_flag = (col == '0);
  assign end_flag   = (col == row_len - RL_ONE);
  assign last_row   = (row == num_rows - RL_ONE);
  assign push       = din_valid && din_ready;
  assign valid      = !empty;
  assign busy       = (state != IDLE);

  always_comb begin
    wdata                 = '0;
    wdata[SB]             = start_flag;
    wdata[EB]             = end_flag;
    wdata[DATA_WIDTH-1:0] = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    cfg_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start && row_len_in != '0) begin
          cfg_load  = 1'b1;
          state_nxt = (num_rows_in == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        din_ready = !full;
        if (din_valid && !full && end_flag && last_row) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (count == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_len  <= '0;
      num_rows <= '0;
      col      <= '0;
      row      <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DRAIN) && (count == '0);
      if (cfg_load) begin
        row_len  <= row_len_in;
        num_rows <= num_rows_in;
        col      <= '0;
        row      <= '0;
      end else if (push) begin
        if (end_flag) begin
          col <= '0;
          row <= row + RL_ONE;
        end else begin
          col <= col + RL_ONE;
        end
      end
    end
  end

`ifdef IFMAP_FRAMER_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       words_sent <= '0;
    else if (cfg_load)                              words_sent <= '0;
    else if (ren && valid && words_sent != 16'hFFFF) words_sent <= words_sent + 16'd1;
  end
`endif

  sync_fifo_showahead #(
    .WIDTH      (DATA_WIDTH + 2),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (ren),
    .rdata (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_ifmap_row_framer.sv
// Randomized bench for ifmap_row_framer against a frame-level queue model.
module tb_ifmap_row_framer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] row_len_in;
  logic [4:0] num_rows_in;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [9:0] dout;
  logic       valid;
  logic       ren;
  logic       busy;
  logic       done;
`ifdef IFMAP_FRAMER_CNT_EN
  logic [15:0] words_sent;
`endif

  ifmap_row_framer #(
    .DATA_WIDTH    (8),
    .DEPTH         (8),
    .ADDR_WIDTH    (3),
    .ROW_LEN_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .row_len_in  (row_len_in),
    .num_rows_in (num_rows_in),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .valid       (valid),
    .ren         (ren),
    .busy        (busy),
    .done        (done)
`ifdef IFMAP_FRAMER_CNT_EN
    ,
    .words_sent  (words_sent)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame-level model: mode 0 idle, 1 accepting words, 2 waiting for drain.
  int         m_mode = 0;
  int         m_k    = 0;
  int         m_R    = 0;
  int         m_N    = 0;
  int         m_cnt  = 0;
  bit         m_done = 0;
  logic [9:0] q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_k    = 0;
    m_done = 0;
    m_cnt  = 0;
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance model one clock.
  task automatic tick(input bit st, input int rl, input int nr,
                      input bit dv, input logic [7:0] d, input bit rn);
    bit         exp_rdy;
    bit         pre_empty;
    bit         do_push;
    logic [9:0] exp_dout;
    int         r;
    exp_rdy   = (m_mode == 1) && (q.size() < 8);
    pre_empty = (q.size() == 0);
    exp_dout  = pre_empty ? 10'd0 : q[0];
    check("busy", {31'd0, busy}, {31'd0, m_mode != 0});
    check("din_ready", {31'd0, din_ready}, {31'd0, exp_rdy});
    check("valid", {31'd0, valid}, {31'd0, !pre_empty});
    check("dout", {22'd0, dout}, {22'd0, exp_dout});
    check("done", {31'd0, done}, {31'd0, m_done});
`ifdef IFMAP_FRAMER_CNT_EN
    check("words_sent", {16'd0, words_sent}, m_cnt);
`endif
    start       = st;
    row_len_in  = rl[4:0];
    num_rows_in = nr[4:0];
    din_valid   = dv;
    din         = d;
    ren         = rn;

    do_push = dv && exp_rdy;
    m_done  = (m_mode == 2) && pre_empty;
    if (rn && !pre_empty) begin
      void'(q.pop_front());
      if (m_cnt < 65535) m_cnt++;
    end
    case (m_mode)
      0: if (st && rl != 0) begin
        m_R    = rl;
        m_N    = nr;
        m_k    = 0;
        m_cnt  = 0;
        m_mode = (nr == 0) ? 2 : 1;
      end
      1: if (do_push) begin
        r = m_k % m_R;
        q.push_back({r == 0, r == m_R - 1, d});
        m_k++;
        if (m_k == m_R * m_N) m_mode = 2;
      end
      default: if (pre_empty) m_mode = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int rl, input int nr, input int vpct,
                           input int rpct, input int hold);
    int n;
    bit saw_done;
    bit dv;
    bit rn;
    bit st;
    tick(1'b1, rl, nr, 1'b0, 8'd0, 1'b0);
    if (m_mode == 0) begin
      tick(1'b0, 0, 0, 1'b0, 8'd0, 1'b1);
      tick(1'b0, 0, 0, 1'b0, 8'd0, 1'b1);
      return;
    end
    n        = 0;
    saw_done = 0;
    while (n < 400) begin
      saw_done = m_done;
      dv = ($urandom_range(99) < vpct);
      rn = (n >= hold) && ($urandom_range(99) < rpct);
      st = (m_mode != 0) && ($urandom_range(99) < 5);
      tick(st, $urandom_range(1, 6), $urandom_range(0, 4), dv, 8'($urandom), rn);
      n++;
      if (saw_done) break;
    end
    if (!saw_done) check("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    row_len_in  = '0;
    num_rows_in = '0;
    din         = '0;
    din_valid   = 1'b0;
    ren         = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dout", {22'd0, dout}, 32'd0);
    check("rst_din_ready", {31'd0, din_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;

    run_frame(3, 2, 100, 100, 0);
    run_frame(1, 3, 100, 100, 0);
    run_frame(5, 2, 100, 100, 15);
    run_frame(2, 0, 100, 100, 0);
    run_frame(0, 2, 100, 100, 0);

    // Abort a frame after four accepted words.
    tick(1'b1, 3, 2, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 0, 0, 1'b1, 8'(i + 1), 1'b0);
    rst = 1'b0;
    #1;
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dout", {22'd0, dout}, 32'd0);
    check("abort_din_ready", {31'd0, din_ready}, 32'd0);
    model_reset();
    #1;
    rst = 1'b1;
    @(negedge clk);
    tick(1'b0, 0, 0, 1'b0, 8'd0, 1'b1);
    tick(1'b0, 0, 0, 1'b0, 8'd0, 1'b1);
    run_frame(3, 2, 100, 100, 0);

    for (int f = 0; f < 25; f++) begin
      run_frame($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(30, 100),
                $urandom_range(20, 100), $urandom_range(0, 10));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifmap_row_framer.md
# ifmap_row_framer

Upstream feeder for the processing element's IFMap input. Accepts a raw stream of activation words and tags each word with start-of-row and end-of-row flags according to a programmed row length and row count. Buffers the tagged words in a small FIFO and presents them on the PE's `IFMap` / `valid_IFMap` / `ren_buf_IFMap` handshake. Sits between the global IFMap buffer or DMA and one PE.

## Interface
- `DATA_WIDTH`, 8, activation word width
- `DEPTH`, 8, FIFO entries (any value ≥2, not restricted to a power of 2)
- `ADDR_WIDTH`, 3, FIFO pointer width, ≥ clog2(DEPTH)
- `ROW_LEN_WIDTH`, 5, width of the row-length and row-count fields

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; latches the configuration
- `row_len_in`  in  ROW_LEN_WIDTH  words per row
- `num_rows_in`  in  ROW_LEN_WIDTH  rows per frame
- `din`  in  DATA_WIDTH  upstream data
- `din_valid`  in  1  upstream word is available
- `din_ready`  out  1  framer accepts `din` this cycle
- `dout`  out  DATA_WIDTH+2  tagged word to the PE: bit DATA_WIDTH+1 = start_row, bit DATA_WIDTH = end_row, low bits = data
- `valid`  out  1  `dout` holds a word; drives the PE's `valid_IFMap`
- `ren`  in  1  PE pop; driven by the PE's `ren_buf_IFMap`
- `busy`  out  1  FSM is not in IDLE
- `done`  out  1  one-cycle pulse when the frame has been fully consumed

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- **IDLE**
  - `start` with `row_len_in ≠ 0` latches `row_len` and `num_rows`, clears the column and row counters, and moves to STREAM.
  - If `num_rows_in = 0`, the FSM moves to DRAIN instead.
  - `start` with `row_len_in = 0` is ignored.
- **STREAM**
  - `din_ready = !full`.
  - A word is pushed when `din_valid && din_ready`.
  - start flag = (col == 0); end flag = (col == row_len−1). Both flags are set when `row_len = 1`.
  - On a push with the end flag set: col resets to 0 and row increments. On the push that completes row `num_rows−1`, the FSM moves to DRAIN.
  - On any other push, col increments.
- **DRAIN**
  - `din_ready = 0`.
  - When the FIFO is empty, `done` pulses for one cycle and the FSM returns to IDLE.
- `start` is ignored outside IDLE.
- **FIFO**
  - Show-ahead: `valid = !empty`; `dout = mem[rptr]` when valid, else 0.
  - A pop occurs on `ren && valid`. `ren` while empty is ignored.
  - Pointers wrap from DEPTH−1 to 0.
  - Occupancy count is ADDR_WIDTH+1 bits.
  - A simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
  - A push is never offered while the FIFO is full.
- `din_ready` is combinational from state and full. It has no combinational dependence on `din_valid`.

## Timing
- Push-to-`valid` latency is 1 cycle: a word accepted at edge N is visible on `dout` after edge N.
- A pop at edge N exposes the next entry after edge N.
- Throughput is one word per cycle in each direction.
- `done` is asserted in the cycle immediately after the state is DRAIN and count reaches 0. It never coincides with `valid`.
- Reset values: `din_ready` 0, `valid` 0, `dout` 0, `busy` 0, `done` 0, FSM IDLE, pointers, counters and count all 0.
- Reset asserted mid-frame discards all buffered words immediately (asynchronous). No `done` is produced for the aborted frame.

## Configuration
- `IFMAP_FRAMER_CNT_EN` defined:
  - Adds output `words_sent [15:0]`, reset to 0 and cleared on an accepted `start`.
  - Increments on every pop and saturates at 16'hFFFF.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Package `ifmap_framer_pkg`:
  - state enum (IDLE / STREAM / DRAIN)
  - constants `START_BIT` = DATA_WIDTH+1 and `END_BIT` = DATA_WIDTH, as functions of the parameter
- One sub-module, `sync_fifo_showahead`: parameterised by width and depth; push, pop, full, empty, count.
- Row/column tagging and the FSM live in the top module.

## Test plan
- row_len=3, num_rows=2, din 1..6, `ren` held 1 -> dout flags start/end = 10,00,01,10,00,01 on data 1..6; `done` pulses one cycle after the 6th pop.
- row_len=1, num_rows=3 -> every word has start=end=1; 3 pops, then `done`.
- DEPTH=8, `ren`=0, 10 words offered -> `din_ready` falls after 8 pushes; releasing `ren` drains all 10 in order with correct flags.
- `start` with num_rows=0 -> `busy` for 1 cycle, `done` pulse, `valid` never asserted; `start` with row_len=0 -> stays IDLE.
- Reset pulsed low after 4 of 6 words -> `valid`=0 and `busy`=0 immediately, no `done`; a new frame then streams correctly.
- With `IFMAP_FRAMER_CNT_EN`, 6-word frame -> `words_sent`=6; the next `start` clears it to 0.
